cell_array_engine: RTL and testbench

- Datapath and board storage for the cellular-automaton game, directly downstream of the FSM.
- The FSM sweeps `count` across every cell and issues `loadData`, `readData` and `writeData` strobes; this block acts on them.
- It holds the current and next generation, applies the B3/S23 life rule with toroidal wrap, and reports population.
- It returns `loseSig` to the FSM when a committed generation is empty.

---
 rtl/cell_array_if.sv | 28 ++
 rtl/cell_array_engine.sv | 112 +++++++++++
 tb/tb_cell_array_engine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cell_array_if.sv
// Strobe/index bus between the game FSM and the cell array engine,
// together with the status signals the engine reports back.
interface cell_array_if #(
    parameter int CW    = 9,
    parameter int GEN_W = 8
);
    logic             loadData;
    logic             inp;
    logic             readData;
    logic             writeData;
    logic [CW-1:0]    count;
    logic             cell_out;
    logic [CW:0]      pop;
    logic [GEN_W-1:0] gen;
    logic             loseSig;

    // FSM side: issues strobes and the cell index, observes status
    modport master (
        output loadData, inp, readData, writeData, count,
        input  cell_out, pop, gen, loseSig
    );

    // Engine side
    modport slave (
        input  loadData, inp, readData, writeData, count,
        output cell_out, pop, gen, loseSig
    );
endinterface

// File: rtl/cell_array_engine.sv
// Board storage and B3/S23 life datapath with toroidal wrap. Holds the
// current and next generation, tracks population and the generation count,
// and flags an empty board after a commit.
module cell_array_engine #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 5,
    parameter int CW       = ROW_BITS + COL_BITS,
    parameter int GEN_W    = 8
) (
    input logic         clka,
    input logic         restart,
    cell_array_if.slave bus
);
    localparam int CELLS = 1 << CW;

    logic [CELLS-1:0]    cur;
    logic [CELLS-1:0]    nxt;
    logic                cell_out_q;
    logic [CW:0]         pop_q;
    logic [GEN_W-1:0]    gen_q;
    logic                lose_q;

    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] nb_row;
    logic [COL_BITS-1:0] nb_col;
    logic                cell_now;
    logic [3:0]          nsum;
    logic                rule_bit;
    logic [CW:0]         pop_nxt;
    logic [CW:0]         pop_load;

    assign row      = bus.count[CW-1:COL_BITS];
    assign col      = bus.count[COL_BITS-1:0];
    assign cell_now = cur[bus.count];

    // Sum the eight neighbours; row/col adds wrap naturally at the field width
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        nsum   = '0;
        nb_row = '0;
        nb_col = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    nb_row = row + ROW_BITS'(dr);
                    nb_col = col + COL_BITS'(dc);
                    nsum   = nsum + 4'(cur[{nb_row, nb_col}]);
                end
            end
        end
    end

    // Life rule: birth on 3, survival on 2 or 3
    assign rule_bit = (nsum == 4'd3) | (cell_now & (nsum == 4'd2));

    // Population of the next board, used when it is committed
    always_comb begin
        pop_nxt = '0;
        for (int i = 0; i < CELLS; i++) begin
            pop_nxt = pop_nxt + (CW+1)'(nxt[i]);
        end
    end

    // Population after a single-cell load at the current index
    always_comb begin
        pop_load = pop_q;
        if (bus.inp && !cell_now) begin
            pop_load = pop_q + (CW+1)'(1);
        end else if (!bus.inp && cell_now) begin
            pop_load = pop_q - (CW+1)'(1);
        end
    end

    // Board and status registers; one strobe acts per cycle, restart first
    always_ff @(posedge clka) begin
        if (restart) begin
            // NOTE: both boards are cleared on restart, so they live in flops, not RAM;
            // the whole-board commit in one edge needs that anyway.
            cur        <= '0;
            nxt        <= '0;
            cell_out_q <= 1'b0;
            pop_q      <= '0;
            gen_q      <= '0;
            lose_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so cell_out sees cur as it was before this edge.
            cell_out_q <= cell_now;
            if (bus.loadData) begin
                cur[bus.count] <= bus.inp;
                pop_q          <= pop_load;
                if (pop_load != '0) begin
                    lose_q <= 1'b0;
                end
            end else if (bus.writeData) begin
                cur    <= nxt;
                pop_q  <= pop_nxt;
                lose_q <= (pop_nxt == '0);
                if (gen_q != '1) begin
                    gen_q <= gen_q + GEN_W'(1);
                end
            end else if (bus.readData) begin
                nxt[bus.count] <= rule_bit;
            end
        end
    end

    assign bus.cell_out = cell_out_q;
    assign bus.pop      = pop_q;
    assign bus.gen      = gen_q;
    assign bus.loseSig  = lose_q;
endmodule

// File: tb/tb_cell_array_engine.sv
// Directed bench for cell_array_engine: loads, sweeps and commits small
// patterns and compares status and read-back boards to hand-derived values.
module tb_cell_array_engine;
    localparam int CW    = 9;
    localparam int GEN_W = 8;
    localparam int CELLS = 1 << CW;

    logic clk = 1'b0;
    logic restart;
    always #5 clk = ~clk;

    cell_array_if #(.CW(CW), .GEN_W(GEN_W)) bus();

    cell_array_engine #(
        .ROW_BITS(4),
        .COL_BITS(5),
        .CW(CW),
        .GEN_W(GEN_W)
    ) dut (
        .clka(clk),
        .restart(restart),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [CELLS-1:0] board;

    task automatic check(input string tag, input logic [CELLS-1:0] got, input logic [CELLS-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic load(input int idx, input logic v);
        bus.loadData = 1'b1;
        bus.inp      = v;
        bus.count    = CW'(idx);
        step();
        bus.loadData = 1'b0;
        bus.inp      = 1'b0;
    endtask

    task automatic sweep();
        bus.readData = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            bus.count = CW'(i);
            step();
        end
        bus.readData = 1'b0;
    endtask

    task automatic commit();
        bus.writeData = 1'b1;
        step();
        bus.writeData = 1'b0;
    endtask

    task automatic read_board(output logic [CELLS-1:0] b);
        b = '0;
        for (int i = 0; i < CELLS; i++) begin
            bus.count = CW'(i);
            step();
            b[i] = bus.cell_out;
        end
    endtask

    // Board with up to four live cells; negative indices are skipped
    function automatic logic [CELLS-1:0] cells(input int a, input int b, input int c, input int d);
        logic [CELLS-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        if (d >= 0) r[d] = 1'b1;
        return r;
    endfunction

    initial begin
        restart       = 1'b0;
        bus.loadData  = 1'b0;
        bus.inp       = 1'b0;
        bus.readData  = 1'b0;
        bus.writeData = 1'b0;
        bus.count     = '0;

        // Reset state
        do_restart();
        check("rst_pop", bus.pop, 0);
        check("rst_gen", bus.gen, 0);
        check("rst_lose", bus.loseSig, 0);
        check("rst_cell", bus.cell_out, 0);

        // Load a horizontal blinker in row 1
        load(32, 1'b1);
        check("load1_pop", bus.pop, 1);
        load(33, 1'b1);
        load(34, 1'b1);
        check("load3_pop", bus.pop, 3);
        check("load3_lose", bus.loseSig, 0);
        check("load3_gen", bus.gen, 0);
        bus.count = CW'(33);
        step();
        check("cell_33", bus.cell_out, 1);
        bus.count = CW'(35);
        step();
        check("cell_35", bus.cell_out, 0);

        // Blinker flips to vertical, then back
        sweep();
        check("sweep_pop_held", bus.pop, 3);
        check("sweep_gen_held", bus.gen, 0);
        commit();
        check("blink1_pop", bus.pop, 3);
        check("blink1_gen", bus.gen, 1);
        check("blink1_lose", bus.loseSig, 0);
        read_board(board);
        check("blink1_board", board, cells(1, 33, 65, -1));
        sweep();
        commit();
        check("blink2_gen", bus.gen, 2);
        read_board(board);
        check("blink2_board", board, cells(32, 33, 34, -1));

        // Toroidal wrap across both row and column edges
        do_restart();
        load(31, 1'b1);
        load(0, 1'b1);
        load(1, 1'b1);
        sweep();
        commit();
        check("wrap_pop", bus.pop, 3);
        read_board(board);
        check("wrap_board", board, cells(480, 0, 32, -1));

        // Extinction and loseSig hold/clear behaviour
        do_restart();
        load(100, 1'b1);
        sweep();
        commit();
        check("ext_pop", bus.pop, 0);
        check("ext_lose", bus.loseSig, 1);
        check("ext_gen", bus.gen, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ext_lose_hold", bus.loseSig, 1);
        end
        load(7, 1'b0);
        check("ext_load0_pop", bus.pop, 0);
        check("ext_load0_lose", bus.loseSig, 1);
        load(5, 1'b1);
        check("ext_load5_pop", bus.pop, 1);
        check("ext_load5_lose", bus.loseSig, 0);
        check("ext_load5_cell_old", bus.cell_out, 0);
        load(5, 1'b0);
        check("ext_clear5_pop", bus.pop, 0);
        check("ext_clear5_lose", bus.loseSig, 0);
        check("ext_clear5_cell_old", bus.cell_out, 1);

        // Priority: load beats a simultaneous commit
        do_restart();
        load(0, 1'b1);
        load(1, 1'b1);
        load(32, 1'b1);
        load(33, 1'b1);
        sweep();
        bus.loadData  = 1'b1;
        bus.writeData = 1'b1;
        bus.inp       = 1'b1;
        bus.count     = CW'(200);
        step();
        bus.loadData  = 1'b0;
        bus.writeData = 1'b0;
        bus.inp       = 1'b0;
        check("prio_pop", bus.pop, 5);
        check("prio_gen", bus.gen, 0);
        commit();
        check("block_pop", bus.pop, 4);
        check("block_gen", bus.gen, 1);
        read_board(board);
        check("block_board", board, cells(0, 1, 32, 33));

        // Restart in the middle of a sweep discards the partial next board
        bus.readData = 1'b1;
        for (int i = 0; i < 250; i++) begin
            bus.count = CW'(i);
            step();
        end
        bus.count = CW'(250);
        restart   = 1'b1;
        step();
        restart      = 1'b0;
        bus.readData = 1'b0;
        check("mid_pop", bus.pop, 0);
        check("mid_gen", bus.gen, 0);
        check("mid_lose", bus.loseSig, 0);
        check("mid_cell", bus.cell_out, 0);
        commit();
        check("mid_commit_lose", bus.loseSig, 1);
        check("mid_commit_pop", bus.pop, 0);
        check("mid_commit_gen", bus.gen, 1);
        read_board(board);
        check("mid_board", board, '0);

        // Generation counter saturates
        for (int i = 0; i < 260; i++) begin
            commit();
        end
        check("gen_sat", bus.gen, 255);
        do_restart();
        check("gen_clr", bus.gen, 0);
        check("lose_clr", bus.loseSig, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
